// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the MMIO responder: window base, register offsets,
// timer control bit positions and the CPU data-memory access type codes.
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    localparam logic [7:0] OFF_SW     = 8'h00;
    localparam logic [7:0] OFF_LED    = 8'h04;
    localparam logic [7:0] OFF_SEG_LO = 8'h08;
    localparam logic [7:0] OFF_SEG_HI = 8'h0C;
    localparam logic [7:0] OFF_CYCLE  = 8'h10;
    localparam logic [7:0] OFF_TCMP   = 8'h14;
    localparam logic [7:0] OFF_TCTRL  = 8'h18;
    localparam logic [7:0] OFF_STATUS = 8'h1C;

    localparam int TCTRL_EN     = 0;
    localparam int TCTRL_PEND   = 1;
    localparam int TCTRL_RELOAD = 2;
    localparam int TCTRL_IRQEN  = 3;

    typedef enum logic [2:0] {
        DM_WORD   = 3'b000,
        DM_HALF   = 3'b001,
        DM_HALF_U = 3'b010,
        DM_BYTE   = 3'b011,
        DM_BYTE_U = 3'b100
    } dmtype_e;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_e;

    // Offsets that accept a store; SW and CYCLE are read-only.
    function automatic logic reg_writable(input logic [7:0] off);
        case (off)
            OFF_LED, OFF_SEG_LO, OFF_SEG_HI,
            OFF_TCMP, OFF_TCTRL, OFF_STATUS: reg_writable = 1'b1;
            default:                         reg_writable = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// CPU data-bus view of the MMIO window: the CPU memory stage is the master,
// the responder is the slave.
interface mmio_responder_if;
    logic        io_we;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic [2:0]  io_dmtype;
    logic        io_hit;
    logic [31:0] io_rdata;

    modport master (
        output io_we, io_addr, io_wdata, io_dmtype,
        input  io_hit, io_rdata
    );

    modport slave (
        input  io_we, io_addr, io_wdata, io_dmtype,
        output io_hit, io_rdata
    );
endinterface

// File: rtl/mmio_responder_io_timer.sv
// Compare timer: free-running TCNT while enabled, match against TCMP sets a
// sticky pending flag, optional auto-reload, level interrupt.
module io_timer
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        tcmp_we_i,
    input  logic        tctrl_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] tcmp_o,
    output logic [31:0] tctrl_o,
    output logic        irq_o
);

    tmr_state_e  state_q;
    logic [31:0] tcnt_q;
    logic [31:0] tcmp_q;
    logic        pend_q;
    logic        reload_q;
    logic        irqen_q;
    logic        irq_q;

    logic match;
    logic pend_clr;
    logic pend_d;
    logic irqen_d;

    assign match    = (state_q == TMR_RUN) && (tcnt_q == tcmp_q);
    assign pend_clr = tctrl_we_i && wdata_i[TCTRL_PEND];
    // A match in the same edge as the W1C keeps the flag set.
    assign pend_d   = match | (pend_q & ~pend_clr);
    assign irqen_d  = tctrl_we_i ? wdata_i[TCTRL_IRQEN] : irqen_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= TMR_IDLE;
            tcnt_q   <= 32'd0;
            tcmp_q   <= 32'hFFFF_FFFF;
            pend_q   <= 1'b0;
            reload_q <= 1'b0;
            irqen_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (tcmp_we_i) tcmp_q <= wdata_i;
            if (tctrl_we_i) reload_q <= wdata_i[TCTRL_RELOAD];
            irqen_q <= irqen_d;
            pend_q  <= pend_d;
            irq_q   <= pend_d & irqen_d;

            case (state_q)
                TMR_IDLE: begin
                    if (tctrl_we_i && wdata_i[TCTRL_EN]) begin
                        state_q <= TMR_RUN;
                        tcnt_q  <= 32'd0;
                    end
                end
                TMR_RUN: begin
                    if (match) begin
                        if (reload_q) tcnt_q <= 32'd0;
                    end else begin
                        tcnt_q <= tcnt_q + 32'd1;
                    end
                    // One-shot mode parks TCNT at TCMP and drops EN.
                    if (tctrl_we_i)
                        state_q <= wdata_i[TCTRL_EN] ? TMR_RUN : TMR_IDLE;
                    else if (match && !reload_q)
                        state_q <= TMR_IDLE;
                end
                default: state_q <= TMR_IDLE;
            endcase
        end
    end

    assign tcmp_o  = tcmp_q;
    assign tctrl_o = {28'd0, irqen_q, reload_q, pend_q, (state_q == TMR_RUN)};
    assign irq_o   = irq_q;

endmodule

// File: rtl/mmio_responder.sv
// MMIO target on the CPU data bus: switch sync, LEDs, tear-free 64-bit
// seven-segment word, cycle counter, compare timer and sticky bus error.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE  = MMIO_BASE_DEFAULT,
    parameter int          SW_W  = 16,
    parameter int          LED_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    mmio_responder_if.slave   bus,
    input  logic [SW_W-1:0]   sw_i,
    output logic [LED_W-1:0]  led_o,
    output logic [63:0]       seg_data_o,
    output logic              irq_o
);

    logic [SW_W-1:0]  sw_meta_q;
    logic [SW_W-1:0]  sw_sync_q;
    logic [LED_W-1:0] led_q;
    logic [31:0]      seg_lo_q;
    logic [63:0]      seg_q;
    logic [31:0]      cycle_q;
    logic             err_q;
    logic             err_d;

    logic        hit;
    logic [7:0]  off;
    logic [7:0]  word_off;
    logic        wr_ok;
    logic        wr_err;
    logic [31:0] sw_ext;
    logic [31:0] led_ext;
    logic [31:0] tcmp;
    logic [31:0] tctrl;
    logic [31:0] rdata;

    assign hit      = (bus.io_addr[31:8] == BASE[31:8]);
    assign off      = bus.io_addr[7:0];
    assign word_off = {bus.io_addr[7:2], 2'b00};

    // Only aligned word stores to writable registers land; anything else that
    // hits the window is dropped and flagged.
    assign wr_ok  = bus.io_we && hit && (bus.io_dmtype == DM_WORD) &&
                    (bus.io_addr[1:0] == 2'b00) && reg_writable(off);
    assign wr_err = bus.io_we && hit && !wr_ok;
    assign err_d  = wr_err | (err_q & ~(wr_ok && off == OFF_STATUS && bus.io_wdata[0]));

    io_timer u_timer (
        .clk       (clk),
        .rstn      (rstn),
        .tcmp_we_i (wr_ok && off == OFF_TCMP),
        .tctrl_we_i(wr_ok && off == OFF_TCTRL),
        .wdata_i   (bus.io_wdata),
        .tcmp_o    (tcmp),
        .tctrl_o   (tctrl),
        .irq_o     (irq_o)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            led_q     <= '0;
            seg_lo_q  <= 32'hFFFF_FFFF;
            seg_q     <= 64'hFFFF_FFFF_FFFF_FFFF;
            cycle_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            sw_meta_q <= sw_i;
            sw_sync_q <= sw_meta_q;
            cycle_q   <= cycle_q + 32'd1;
            err_q     <= err_d;
            if (wr_ok && off == OFF_LED)    led_q    <= bus.io_wdata[LED_W-1:0];
            if (wr_ok && off == OFF_SEG_LO) seg_lo_q <= bus.io_wdata;
            // The high-word store commits both halves at once.
            if (wr_ok && off == OFF_SEG_HI) seg_q    <= {bus.io_wdata, seg_lo_q};
        end
    end

    always_comb begin
        sw_ext              = '0;
        sw_ext[SW_W-1:0]    = sw_sync_q;
        led_ext             = '0;
        led_ext[LED_W-1:0]  = led_q;
    end

    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (word_off)
                OFF_SW:     rdata = sw_ext;
                OFF_LED:    rdata = led_ext;
                OFF_SEG_LO: rdata = seg_lo_q;
                OFF_SEG_HI: rdata = seg_q[63:32];
                OFF_CYCLE:  rdata = cycle_q;
                OFF_TCMP:   rdata = tcmp;
                OFF_TCTRL:  rdata = tctrl;
                OFF_STATUS: rdata = {31'd0, err_q};
                default:    rdata = 32'd0;
            endcase
        end
    end

    assign bus.io_hit   = hit;
    assign bus.io_rdata = rdata;
    assign led_o        = led_q;
    assign seg_data_o   = seg_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: bus reads/writes, switch sync, SEG
// commit, timer reload/one-shot, bus error and asynchronous reset.
module tb_mmio_responder;

    localparam logic [31:0] B = 32'hFFFF_0000;

    logic        clk;
    logic        rstn;
    logic [15:0] sw_i;
    logic [15:0] led_o;
    logic [63:0] seg_data_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] cyc0;

    mmio_responder_if bus();

    mmio_responder dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .sw_i      (sw_i),
        .led_o     (led_o),
        .seg_data_o(seg_data_o),
        .irq_o     (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [2:0] t,
                          input logic [31:0] exp, input string tag);
        bus.io_we     = 1'b0;
        bus.io_addr   = a;
        bus.io_dmtype = t;
        #1;
        chk(tag, {32'd0, bus.io_rdata}, {32'd0, exp});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        @(negedge clk);
        bus.io_we     = 1'b1;
        bus.io_addr   = a;
        bus.io_wdata  = d;
        bus.io_dmtype = t;
        @(posedge clk);
        #1;
        bus.io_we     = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rstn          = 1'b0;
        sw_i          = 16'h0000;
        bus.io_we     = 1'b0;
        bus.io_addr   = B;
        bus.io_wdata  = 32'd0;
        bus.io_dmtype = 3'b000;

        // Reset state, read while reset is held.
        tick(3);
        rd_chk(B + 32'h00, 3'b000, 32'h0000_0000, "rst_sw");
        rd_chk(B + 32'h04, 3'b000, 32'h0000_0000, "rst_led");
        rd_chk(B + 32'h08, 3'b000, 32'hFFFF_FFFF, "rst_seg_lo");
        rd_chk(B + 32'h0C, 3'b000, 32'hFFFF_FFFF, "rst_seg_hi");
        rd_chk(B + 32'h10, 3'b000, 32'h0000_0000, "rst_cycle");
        rd_chk(B + 32'h14, 3'b000, 32'hFFFF_FFFF, "rst_tcmp");
        rd_chk(B + 32'h18, 3'b000, 32'h0000_0000, "rst_tctrl");
        rd_chk(B + 32'h1C, 3'b000, 32'h0000_0000, "rst_status");
        chk("rst_seg_out", seg_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_irq", {63'd0, irq_o}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick(1);
        rd_chk(B + 32'h20, 3'b000, 32'h0000_0000, "unmapped_rd");

        // Switch synchronizer latency and LED store.
        @(negedge clk);
        sw_i = 16'hA5C3;
        tick(1);
        rd_chk(B + 32'h00, 3'b000, 32'h0000_0000, "sw_n1");
        tick(1);
        rd_chk(B + 32'h00, 3'b000, 32'h0000_A5C3, "sw_n2");
        wr(B + 32'h04, 32'h1234_5678, 3'b000);
        chk("led_out", {48'd0, led_o}, 64'h5678);
        rd_chk(B + 32'h04, 3'b000, 32'h0000_5678, "led_rd");
        rd_chk(B + 32'h05, 3'b011, 32'h0000_5678, "led_rd_byte");

        // SEG shadow and atomic commit.
        wr(B + 32'h08, 32'h1111_2222, 3'b000);
        chk("seg_lo_no_commit", seg_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_chk(B + 32'h08, 3'b000, 32'h1111_2222, "seg_lo_rd");
        wr(B + 32'h0C, 32'h3333_4444, 3'b000);
        chk("seg_commit", seg_data_o, 64'h3333_4444_1111_2222);
        rd_chk(B + 32'h0C, 3'b000, 32'h3333_4444, "seg_hi_rd");

        // Timer with reload and interrupt enable.
        wr(B + 32'h14, 32'd5, 3'b000);
        wr(B + 32'h18, 32'hD, 3'b000);
        chk("t4_tcnt_start", {32'd0, dut.u_timer.tcnt_q}, 64'd0);
        tick(5);
        chk("t4_irq_early", {63'd0, irq_o}, 64'd0);
        chk("t4_tcnt5", {32'd0, dut.u_timer.tcnt_q}, 64'd5);
        tick(1);
        chk("t4_irq_rise", {63'd0, irq_o}, 64'd1);
        chk("t4_tcnt_reload", {32'd0, dut.u_timer.tcnt_q}, 64'd0);
        rd_chk(B + 32'h18, 3'b000, 32'hF, "t4_tctrl");
        tick(5);
        wr(B + 32'h18, 32'hF, 3'b000);
        chk("t4_set_wins_irq", {63'd0, irq_o}, 64'd1);
        rd_chk(B + 32'h18, 3'b000, 32'hF, "t4_set_wins_tctrl");
        wr(B + 32'h18, 32'h2, 3'b000);
        chk("t4_stop_irq", {63'd0, irq_o}, 64'd0);
        rd_chk(B + 32'h18, 3'b000, 32'h0, "t4_stop_tctrl");

        // One-shot timer.
        wr(B + 32'h14, 32'd3, 3'b000);
        wr(B + 32'h18, 32'h9, 3'b000);
        tick(3);
        chk("t5_irq_early", {63'd0, irq_o}, 64'd0);
        tick(1);
        chk("t5_irq", {63'd0, irq_o}, 64'd1);
        chk("t5_tcnt_hold", {32'd0, dut.u_timer.tcnt_q}, 64'd3);
        rd_chk(B + 32'h18, 3'b000, 32'hA, "t5_tctrl");
        tick(3);
        chk("t5_tcnt_still", {32'd0, dut.u_timer.tcnt_q}, 64'd3);
        wr(B + 32'h18, 32'hA, 3'b000);
        chk("t5_w1c_irq", {63'd0, irq_o}, 64'd0);
        rd_chk(B + 32'h18, 3'b000, 32'h8, "t5_w1c_tctrl");
        tick(8);
        chk("t5_no_more_irq", {63'd0, irq_o}, 64'd0);

        // Bus errors.
        wr(B + 32'h04, 32'h0000_00FF, 3'b011);
        chk("err_sb_led", {48'd0, led_o}, 64'h5678);
        rd_chk(B + 32'h1C, 3'b000, 32'h1, "err_sb_status");
        wr(B + 32'h1C, 32'h1, 3'b000);
        rd_chk(B + 32'h1C, 3'b000, 32'h0, "err_w1c");
        tick(1);
        bus.io_addr = B + 32'h10;
        #1;
        cyc0 = bus.io_rdata;
        wr(B + 32'h10, 32'h0, 3'b000);
        rd_chk(B + 32'h10, 3'b000, cyc0 + 32'd1, "cycle_ro");
        rd_chk(B + 32'h1C, 3'b000, 32'h1, "err_cycle_status");
        wr(B + 32'h1C, 32'h1, 3'b000);
        wr(B + 32'h40, 32'h1, 3'b000);
        rd_chk(B + 32'h1C, 3'b000, 32'h1, "err_unmapped_status");
        wr(B + 32'h1C, 32'h1, 3'b000);
        wr(B + 32'h06, 32'h0000_BEEF, 3'b000);
        chk("err_misalign_led", {48'd0, led_o}, 64'h5678);
        rd_chk(B + 32'h1C, 3'b000, 32'h1, "err_misalign_status");
        wr(B + 32'h1C, 32'h1, 3'b000);
        rd_chk(32'h0000_0010, 3'b000, 32'h0, "miss_rdata");
        chk("miss_hit", {63'd0, bus.io_hit}, 64'd0);
        wr(32'h0000_0010, 32'hDEAD, 3'b000);
        rd_chk(B + 32'h1C, 3'b000, 32'h0, "miss_no_err");
        chk("hit_in_window", {63'd0, bus.io_hit}, 64'd1);

        // Asynchronous reset while the timer is interrupting.
        wr(B + 32'h14, 32'd2, 3'b000);
        wr(B + 32'h18, 32'hD, 3'b000);
        tick(3);
        chk("rst_mid_irq_before", {63'd0, irq_o}, 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_mid_irq", {63'd0, irq_o}, 64'd0);
        chk("rst_mid_led", {48'd0, led_o}, 64'd0);
        chk("rst_mid_seg", seg_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        rstn = 1'b1;
        tick(2);
        chk("rst_rel_irq", {63'd0, irq_o}, 64'd0);
        rd_chk(B + 32'h18, 3'b000, 32'h0, "rst_rel_tctrl");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
